// File: rtl/keycode_avalon_writer.sv
// keycode_avalon_writer: Avalon-MM write master that forwards keycodes from a
// keyboard source into an 8-bit keycode PIO data register. Keys are buffered in
// a small FIFO, optionally de-duplicated against the last written key, and each
// surviving key is issued as one waitrequest-aware write.
module keycode_avalon_writer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 2,
  parameter int TARGET_ADDR = 0,
  parameter int SKIP_REPEAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [7:0]                    key_data,
  output logic                          key_ready,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  output logic [3:0]                    avm_byteenable,
  input  logic                          avm_waitrequest,
  input  logic                          clear_overflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0]  FULL_LEVEL_C  = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] TARGET_ADDR_C = ADDR_W'(TARGET_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [7:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic [7:0]         last_key_r;
  logic               overflow_r;
  logic               write_r;
  logic [31:0]        writedata_r;

  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               drop_s;
  logic               pop_s;
  logic               load_s;
  logic               done_s;
  logic               skip_s;
  logic [7:0]         head_s;

  // Occupancy flags and source handshake derived from registered FIFO state.
  always_comb begin
    full_s  = (level_r == FULL_LEVEL_C);
    empty_s = (level_r == {LVL_W{1'b0}});
    push_s  = key_valid && !full_s;
    drop_s  = key_valid && full_s;
    head_s  = mem_r[rd_ptr_r];
  end

  // Repeat filter: a head matching the last delivered key is discarded.
  always_comb begin
    if ((SKIP_REPEAT != 0) && (head_s == last_key_r)) begin
      skip_s = 1'b1;
    end else begin
      skip_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> WRITE -> GAP write sequencer.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (skip_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            load_s      = 1'b1;
            state_nxt_s = ST_WRITE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!avm_waitrequest) begin
          done_s      = 1'b1;
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_GAP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage, wrapping pointers and occupancy; reset flushes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= key_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Registered bus request: raised on load, held through waitrequest, dropped on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_r     <= 1'b0;
      writedata_r <= 32'h0000_0000;
    end else if (load_s) begin
      write_r     <= 1'b1;
      writedata_r <= {24'h00_0000, head_s};
    end else if (done_s) begin
      write_r     <= 1'b0;
    end
  end

  // Last successfully delivered keycode, used by the repeat filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_key_r <= 8'h00;
    end else if (done_s) begin
      last_key_r <= writedata_r[7:0];
    end
  end

  // Sticky overflow: a drop sets it and wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  assign key_ready      = !full_s;
  assign avm_address    = TARGET_ADDR_C;
  assign avm_write      = write_r;
  assign avm_writedata  = writedata_r;
  assign avm_byteenable = 4'b0001;
  assign overflow       = overflow_r;
  assign fifo_level     = level_r;
  assign busy           = !empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_keycode_avalon_writer.sv
// Directed bench for keycode_avalon_writer: a repeat-filtering instance and a
// non-filtering instance, each with an expected-write queue checked on the bus.
module tb_keycode_avalon_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid, key_valid2;
  logic [7:0]  key_data, key_data2;
  logic        waitreq, waitreq2;
  logic        clear_ov, clear_ov2;

  logic        key_ready, key_ready2;
  logic [1:0]  avm_address, avm_address2;
  logic        avm_write, avm_write2;
  logic [31:0] avm_writedata, avm_writedata2;
  logic [3:0]  avm_byteenable, avm_byteenable2;
  logic        overflow, overflow2;
  logic [2:0]  fifo_level, fifo_level2;
  logic        busy, busy2;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int writes2_seen = 0;
  int base_w, base_w2;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  always #5 clk = ~clk;

  keycode_avalon_writer #(.FIFO_DEPTH(4), .ADDR_W(2), .TARGET_ADDR(0), .SKIP_REPEAT(1)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data),
    .key_ready(key_ready), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(waitreq), .clear_overflow(clear_ov), .overflow(overflow),
    .fifo_level(fifo_level), .busy(busy)
  );

  keycode_avalon_writer #(.FIFO_DEPTH(4), .ADDR_W(2), .TARGET_ADDR(0), .SKIP_REPEAT(0)) dut2 (
    .clk(clk), .reset(reset), .key_valid(key_valid2), .key_data(key_data2),
    .key_ready(key_ready2), .avm_address(avm_address2), .avm_write(avm_write2),
    .avm_writedata(avm_writedata2), .avm_byteenable(avm_byteenable2),
    .avm_waitrequest(waitreq2), .clear_overflow(clear_ov2), .overflow(overflow2),
    .fifo_level(fifo_level2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Bus monitor: every cycle with a request is compared to the queue head;
  // the head is retired on the accepting cycle.
  task automatic monitor();
    if (!reset && avm_write) begin
      check("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("wdata", avm_writedata, {24'h0, exp_q[0]});
        check("addr", {30'b0, avm_address}, 32'd0);
        check("byteen", {28'b0, avm_byteenable}, 32'd1);
        if (!waitreq) begin
          void'(exp_q.pop_front());
          writes_seen++;
        end
      end
    end
    if (!reset && avm_write2) begin
      check("write2_expected", {31'b0, exp2_q.size() != 0}, 32'd1);
      if (exp2_q.size() != 0) begin
        check("wdata2", avm_writedata2, {24'h0, exp2_q[0]});
        if (!waitreq2) begin
          void'(exp2_q.pop_front());
          writes2_seen++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || exp2_q.size() != 0 || busy || busy2); i++) begin
      tick();
    end
    check("drain_queue", exp_q.size() + exp2_q.size(), 32'd0);
    check("drain_busy", {30'b0, busy, busy2}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_data = 8'h00; waitreq = 1'b0; clear_ov = 1'b0;
    key_valid2 = 1'b0; key_data2 = 8'h00; waitreq2 = 1'b0; clear_ov2 = 1'b0;
    #12;
    check("rst_write", {31'b0, avm_write}, 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_level", {29'b0, fifo_level}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_key_ready", {31'b0, key_ready}, 32'd1);

    // Single write, no stall: high for exactly one cycle after push edge + 1.
    key_valid = 1'b1; key_data = 8'h1A; exp_q.push_back(8'h1A);
    tick();
    key_valid = 1'b0;
    check("t1_write_e", {31'b0, avm_write}, 32'd0);
    check("t1_level_e", {29'b0, fifo_level}, 32'd1);
    tick();
    check("t1_write_e1", {31'b0, avm_write}, 32'd1);
    check("t1_wdata", avm_writedata, 32'h0000_001A);
    tick();
    check("t1_write_e2", {31'b0, avm_write}, 32'd0);
    check("t1_busy_gap", {31'b0, busy}, 32'd1);
    tick();
    check("t1_busy_idle", {31'b0, busy}, 32'd0);
    check("t1_done", exp_q.size(), 32'd0);

    // Stalled write: held stable six cycles.
    key_valid = 1'b1; key_data = 8'h04; waitreq = 1'b1; exp_q.push_back(8'h04);
    tick();
    key_valid = 1'b0;
    tick();
    check("t2_write_c1", {31'b0, avm_write}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_write_hold", {31'b0, avm_write}, 32'd1);
      check("t2_wdata_hold", avm_writedata, 32'h0000_0004);
    end
    waitreq = 1'b0;
    tick();
    check("t2_write_done", {31'b0, avm_write}, 32'd0);
    check("t2_busy_gap", {31'b0, busy}, 32'd1);
    tick();
    check("t2_busy_idle", {31'b0, busy}, 32'd0);
    check("t2_done", exp_q.size(), 32'd0);

    // Repeat filter: 07,07,16 -> two writes with filter, three without.
    base_w = writes_seen; base_w2 = writes2_seen;
    exp_q.push_back(8'h07); exp_q.push_back(8'h16);
    exp2_q.push_back(8'h07); exp2_q.push_back(8'h07); exp2_q.push_back(8'h16);
    key_valid = 1'b1; key_valid2 = 1'b1;
    key_data = 8'h07; key_data2 = 8'h07; tick();
    key_data = 8'h07; key_data2 = 8'h07; tick();
    key_data = 8'h16; key_data2 = 8'h16; tick();
    key_valid = 1'b0; key_valid2 = 1'b0;
    drain();
    check("t3_skip_writes", writes_seen - base_w, 32'd2);
    check("t3_noskip_writes", writes2_seen - base_w2, 32'd3);

    // Overflow: six keys under a held stall, the sixth dropped.
    base_w = writes_seen;
    waitreq = 1'b1;
    for (int k = 0; k < 6; k++) begin
      key_valid = 1'b1; key_data = 8'h31 + 8'(k);
      if (k < 5) exp_q.push_back(8'h31 + 8'(k));
      tick();
    end
    key_valid = 1'b0;
    check("t4_level_full", {29'b0, fifo_level}, 32'd4);
    check("t4_key_ready", {31'b0, key_ready}, 32'd0);
    check("t4_overflow", {31'b0, overflow}, 32'd1);
    check("t4_wdata_first", avm_writedata, 32'h0000_0031);
    key_valid = 1'b1; key_data = 8'h37; clear_ov = 1'b1;
    tick();
    key_valid = 1'b0; clear_ov = 1'b0;
    check("t4_set_wins", {31'b0, overflow}, 32'd1);
    check("t4_level_hold", {29'b0, fifo_level}, 32'd4);
    waitreq = 1'b0;
    drain();
    check("t4_writes", writes_seen - base_w, 32'd5);
    clear_ov = 1'b1;
    tick();
    clear_ov = 1'b0;
    check("t4_cleared", {31'b0, overflow}, 32'd0);

    // Reset mid-transfer with two keys queued.
    waitreq = 1'b1;
    key_valid = 1'b1; key_data = 8'h41; exp_q.push_back(8'h41); tick();
    key_data = 8'h42; tick();
    key_data = 8'h43; tick();
    key_valid = 1'b0;
    check("t5_write_pre", {31'b0, avm_write}, 32'd1);
    check("t5_level_pre", {29'b0, fifo_level}, 32'd2);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("t5_write_async", {31'b0, avm_write}, 32'd0);
    check("t5_level_async", {29'b0, fifo_level}, 32'd0);
    tick();
    reset = 1'b0; waitreq = 1'b0;
    tick();
    base_w = writes_seen;
    key_valid = 1'b1; key_data = 8'h00; tick();
    key_data = 8'h2C; exp_q.push_back(8'h2C); tick();
    key_valid = 1'b0;
    drain();
    check("t5_single_write", writes_seen - base_w, 32'd1);

    // Push and pop on the same edge at level 2.
    waitreq = 1'b1;
    key_valid = 1'b1; key_data = 8'h51; exp_q.push_back(8'h51); tick();
    key_data = 8'h52; exp_q.push_back(8'h52); tick();
    key_data = 8'h53; exp_q.push_back(8'h53); tick();
    key_valid = 1'b0; waitreq = 1'b0;
    tick();
    check("t6_level_gap", {29'b0, fifo_level}, 32'd2);
    tick();
    check("t6_level_idle", {29'b0, fifo_level}, 32'd2);
    check("t6_write_idle", {31'b0, avm_write}, 32'd0);
    key_valid = 1'b1; key_data = 8'h54; exp_q.push_back(8'h54);
    tick();
    key_valid = 1'b0;
    check("t6_level_pushpop", {29'b0, fifo_level}, 32'd2);
    check("t6_wdata", avm_writedata, 32'h0000_0052);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_avalon_writer.md
Name: keycode_avalon_writer

Overview:
- Avalon-MM master that delivers keycodes from a hardware keyboard source into the 8-bit keycode PIO output register, over that register's memory-mapped slave port.
- Incoming keycodes are buffered in a small FIFO, optionally de-duplicated, then each is issued as a single Avalon write that honours waitrequest.
- Sits between a keyboard/scan decoder and the keycode PIO slave, so software no longer has to forward keycodes.

Parameters:
- FIFO_DEPTH, 4, keycode FIFO entries; power of two, 2..16.
- ADDR_W, 2, width of avm_address.
- TARGET_ADDR, 0, word address of the keycode data register in the slave.
- SKIP_REPEAT, 1, when 1 a popped keycode equal to the last written keycode is discarded with no bus write.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  source presents key_data.
- key_data  in  8  keycode from source.
- key_ready  out  1  FIFO can accept; equals !full (combinational from registered state only).
- avm_address  out  ADDR_W  constant TARGET_ADDR.
- avm_write  out  1  write request, registered.
- avm_writedata  out  32  {24'b0, keycode}, registered.
- avm_byteenable  out  4  constant 4'b0001.
- avm_waitrequest  in  1  slave stall.
- clear_overflow  in  1  synchronous clear of overflow.
- overflow  out  1  sticky: a key was offered while FIFO full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset state (asynchronous on reset=1):
  - avm_write=0, avm_writedata=0, FIFO empty, fifo_level=0, overflow=0, last_key=0, FSM=IDLE.
  - key_ready=1 once reset deasserts.
- Push: key_valid && key_ready at an edge writes key_data into the FIFO tail.
- key_valid && !key_ready at an edge: key dropped, overflow set to 1 at that edge.
- clear_overflow at an edge clears overflow. If a drop occurs at the same edge, set wins and overflow stays 1.
- FSM states:
  - IDLE: if FIFO non-empty at an edge, pop the head.
    - If SKIP_REPEAT=1 and head==last_key: discard it and stay IDLE.
    - Otherwise load avm_writedata={24'b0,head} and avm_write=1, go to WRITE.
  - WRITE: hold avm_write, address and writedata stable while avm_waitrequest=1.
    - At the first edge with avm_waitrequest=0: transfer complete, last_key<=writedata[7:0], avm_write<=0, go to GAP.
  - GAP: one idle cycle, avm_write=0, then go to IDLE.
- Latency and throughput:
  - A key pushed at edge E with an empty FIFO and idle FSM is visible on avm_write starting after edge E+1.
  - With waitrequest=0, minimum spacing between write starts is 3 cycles (IDLE, WRITE, GAP).
- Push and pop in the same edge: both happen; fifo_level is unchanged.
  - No push can occur when full (key_ready=0), so there is no full-boundary race.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- Reset mid-transfer:
  - avm_write drops immediately and the transfer is abandoned.
  - FIFO contents are flushed, and last_key returns to 0.
- waitrequest is ignored outside WRITE.
- With SKIP_REPEAT=1, keycode 0x00 after reset is never written, because last_key=0.
- Only writes are issued; the master never reads.

Test Plan:
- Push 0x1A with waitrequest=0 -> avm_write high for exactly 1 cycle starting after push edge+1; writedata=0x0000001A, address=TARGET_ADDR, byteenable=0001.
- Push 0x04, waitrequest=1 for 5 cycles -> avm_write and writedata 0x04 held stable for 6 cycles; completes on the first waitrequest=0 edge; busy falls after GAP.
- SKIP_REPEAT=1, push 0x07,0x07,0x16 -> exactly two writes, 0x07 then 0x16. Repeat with SKIP_REPEAT=0 -> three writes.
- FIFO_DEPTH=4, waitrequest=1 held, push 6 keys -> first popped into WRITE, fifo_level reaches 4, key_ready=0, overflow=1. Release waitrequest -> 5 writes in order. clear_overflow -> overflow=0.
- Assert reset during WRITE with 2 keys queued -> avm_write=0 asynchronously, fifo_level=0. After release, push 0x2C -> single write of 0x2C.
- Push and pop at the same edge with fifo_level=2 -> fifo_level remains 2, data order preserved.
